// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between the CPU load/store path and the on-chip uart.
// Provides a buffered RX FIFO, a single-entry TX holding register and free-running cycle and instruction counters.
module uart_mmio_bridge #(
  parameter int          RX_DEPTH = 8,
  parameter logic [31:0] IO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        instr_retired,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RX_DEPTH);

  localparam logic [5:0] REG_STATUS = 6'h00;
  localparam logic [5:0] REG_RXDATA = 6'h01;
  localparam logic [5:0] REG_TXDATA = 6'h02;
  localparam logic [5:0] REG_CYCLE  = 6'h04;
  localparam logic [5:0] REG_INSTR  = 6'h05;
  localparam logic [5:0] REG_CLEAR  = 6'h06;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] rx_count;
  logic [31:0]   cycle_count;
  logic [31:0]   instr_count;
  logic [31:0]   read_word;
  logic [5:0]    word_sel;
  logic          in_window;
  logic          rd_en;
  logic          wr_en;
  logic          rx_empty;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;
  logic          tx_store;
  logic          cnt_clear;
  logic          unused_bits;

  // A simultaneous load and store is treated as a load only.
  assign in_window = (addr[31:8] == IO_BASE[31:8]);
  assign word_sel  = addr[7:2];
  assign rd_en     = re && in_window;
  assign wr_en     = we && !re && in_window;

  assign rx_empty      = (rx_count == '0);
  assign rx_full       = (rx_count == FULL_COUNT);
  assign uart_rx_ready = !rx_full;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = rd_en && (word_sel == REG_RXDATA) && !rx_empty;
  assign tx_store      = wr_en && (word_sel == REG_TXDATA);
  assign cnt_clear     = wr_en && (word_sel == REG_CLEAR);
  assign unused_bits   = ^{addr[1:0], wdata[31:8]};

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[wr_ptr] <= uart_rx_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally; occupancy carries one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + PW'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + PW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_comb begin
    read_word = '0;
    if (rd_en) begin
      case (word_sel)
        REG_STATUS: read_word = {30'b0, !rx_empty, !uart_tx_valid};
        REG_RXDATA: read_word = {24'b0, rx_empty ? 8'h00 : rx_mem[rd_ptr]};
        REG_CYCLE:  read_word = cycle_count;
        REG_INSTR:  read_word = instr_count;
        default:    read_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= read_word;
    end
  end

  // A store that lands while the holding register is still busy is dropped, even on the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else if (uart_tx_valid) begin
      if (uart_tx_ready) uart_tx_valid <= 1'b0;
    end else if (tx_store) begin
      uart_tx_valid <= 1'b1;
      uart_tx_data  <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      instr_count <= instr_count + {31'b0, instr_retired};
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed vector table, hand-written corner sequences
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_uart_mmio_bridge;

  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        instr_retired;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  mq[$];
  logic        m_txv;
  logic [7:0]  m_txd;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;
  logic [31:0] m_rdata;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[15];

  uart_mmio_bridge #(.RX_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re), .rdata(rdata),
    .instr_retired(instr_retired),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: evaluates one clock edge from the register-map rules using a byte queue.
  task automatic modelEdge();
    logic       in_win;
    logic [7:0] off;
    logic       rd;
    logic       wr;
    logic       room;
    in_win = (addr[31:8] == BASE[31:8]);
    off    = {addr[7:2], 2'b00};
    rd     = re && in_win;
    wr     = we && !re && in_win;
    if (rst) begin
      mq.delete();
      m_txv = 1'b0; m_txd = 8'h00; m_cyc = 0; m_ins = 0; m_rdata = 0;
    end else begin
      room    = (mq.size() < DEPTH);
      m_rdata = 0;
      if (rd) begin
        case (off)
          8'h00: m_rdata = {30'b0, mq.size() != 0, !m_txv};
          8'h04: if (mq.size() != 0) m_rdata = {24'b0, mq[0]};
          8'h10: m_rdata = m_cyc;
          8'h14: m_rdata = m_ins;
          default: m_rdata = 0;
        endcase
      end
      if (rd && off == 8'h04 && mq.size() != 0) void'(mq.pop_front());
      if (uart_rx_valid && room) mq.push_back(uart_rx_data);
      if (m_txv) begin
        if (uart_tx_ready) m_txv = 1'b0;
      end else if (wr && off == 8'h08) begin
        m_txv = 1'b1;
        m_txd = wdata[7:0];
      end
      if (wr && off == 8'h18) begin
        m_cyc = 0; m_ins = 0;
      end else begin
        m_cyc = m_cyc + 1;
        m_ins = m_ins + {31'b0, instr_retired};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("model rdata", rdata, m_rdata);
    checkOutput("model rx_ready", {31'b0, uart_rx_ready}, {31'b0, mq.size() < DEPTH});
    checkOutput("model tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_txv});
    checkOutput("model tx_data", {24'b0, uart_tx_data}, {24'b0, m_txd});
  endtask

  task automatic applyStimulus(input vec_t v);
    re = v.re; we = v.we; addr = v.addr; wdata = v.wdata;
    uart_rx_valid = v.rxv; uart_rx_data = v.rxd; uart_tx_ready = v.txr;
  endtask

  task automatic idle();
    re = 0; we = 0; addr = 0; wdata = 0; instr_retired = 0;
    uart_rx_valid = 0; uart_rx_data = 0; uart_tx_ready = 0;
  endtask

  task automatic doRead(input logic [31:0] a);
    re = 1; addr = a;
    tick();
    re = 0;
  endtask

  initial begin
    logic pushing;
    int   waited;

    vecs[0]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,  1'b0, 8'h00, 1'b0, 32'h1,  1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 8'h7A, 1'b0, 32'h0,  1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,  1'b0, 8'h00, 1'b0, 32'h3,  1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, BASE + 32'h04, 32'h0,  1'b0, 8'h00, 1'b0, 32'h7A, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,  1'b0, 8'h00, 1'b0, 32'h1,  1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h04, 32'h0,  1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, BASE + 32'h08, 32'h61, 1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b1, 8'h61};
    vecs[7]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,  1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b1, 8'h61};
    vecs[8]  = '{1'b0, 1'b1, BASE + 32'h08, 32'h62, 1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b1, 8'h61};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b0, 8'h00, 1'b1, 32'h0,  1'b1, 1'b0, 8'h61};
    vecs[10] = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,  1'b0, 8'h00, 1'b0, 32'h1,  1'b1, 1'b0, 8'h61};
    vecs[11] = '{1'b1, 1'b0, BASE + 32'h0C, 32'h0,  1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 8'h61};
    vecs[12] = '{1'b1, 1'b0, 32'h9000_0000, 32'h0,  1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 8'h61};
    vecs[13] = '{1'b1, 1'b1, BASE + 32'h08, 32'h33, 1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 8'h61};
    vecs[14] = '{1'b1, 1'b0, BASE + 32'h03, 32'h0,  1'b0, 8'h00, 1'b0, 32'h1,  1'b1, 1'b0, 8'h61};

    idle();
    rst = 1;
    tick();
    tick();
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    checkOutput("reset tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    checkOutput("reset tx_data", {24'b0, uart_tx_data}, 32'h0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d rx_ready", i), {31'b0, uart_rx_ready}, {31'b0, vecs[i].exp_ready});
      checkOutput($sformatf("vec%0d tx_valid", i), {31'b0, uart_tx_valid}, {31'b0, vecs[i].exp_txv});
      checkOutput($sformatf("vec%0d tx_data", i), {24'b0, uart_tx_data}, {24'b0, vecs[i].exp_txd});
    end
    idle();
    tick();

    $display("[TB] FIFO fill to full and drain");
    for (int b = 1; b <= 9; b++) begin
      uart_rx_valid = 1; uart_rx_data = 8'(b);
      if (b == 9) begin
        checkOutput("rx_ready when full", {31'b0, uart_rx_ready}, 32'h0);
      end else begin
        waited = 0;
        while (!uart_rx_ready && waited < 20) begin
          tick();
          waited++;
        end
        if (!uart_rx_ready) checkOutput("push wait expired", 32'h0, 32'h1);
        tick();
      end
    end
    for (int i = 1; i <= 10; i++) begin
      re = 1; addr = BASE + 32'h04;
      pushing = uart_rx_valid && uart_rx_ready;
      tick();
      if (pushing) uart_rx_valid = 0;
      checkOutput($sformatf("drain read %0d", i), rdata, (i <= 9) ? 32'(i) : 32'h0);
    end
    idle();
    tick();

    $display("[TB] full FIFO under continuous push and pop");
    uart_rx_valid = 1; uart_rx_data = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick();
      uart_rx_data = 8'($urandom);
    end
    checkOutput("rx_ready full again", {31'b0, uart_rx_ready}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      re = 1; addr = BASE + 32'h04;
      pushing = uart_rx_valid && uart_rx_ready;
      tick();
      if (pushing) uart_rx_data = 8'($urandom);
    end
    re = 0;
    tick();
    checkOutput("occupancy restored to full", {31'b0, uart_rx_ready}, 32'h0);

    $display("[TB] reset during pending TX");
    uart_rx_valid = 0;
    we = 1; addr = BASE + 32'h08; wdata = 32'h55; uart_tx_ready = 0;
    tick();
    we = 0;
    checkOutput("tx pending before reset", {31'b0, uart_tx_valid}, 32'h1);
    rst = 1;
    tick();
    rst = 0;
    checkOutput("tx_valid after reset", {31'b0, uart_tx_valid}, 32'h0);
    checkOutput("rx_ready after reset", {31'b0, uart_rx_ready}, 32'h1);
    doRead(BASE + 32'h00);
    checkOutput("status after reset", rdata, 32'h1);

    $display("[TB] counters");
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 100; k++) begin
      instr_retired = (k % 5) < 2;
      tick();
    end
    instr_retired = 0;
    doRead(BASE + 32'h10);
    checkOutput("cycle counter", rdata, 32'd100);
    doRead(BASE + 32'h14);
    checkOutput("instr counter", rdata, 32'd40);
    we = 1; addr = BASE + 32'h18; wdata = 32'hFFFF_FFFF;
    tick();
    we = 0;
    doRead(BASE + 32'h10);
    checkOutput("cycle counter cleared", rdata, 32'd0);
    doRead(BASE + 32'h14);
    checkOutput("instr counter cleared", rdata, 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      int sel;
      int kind;
      sel  = $urandom_range(0, 9);
      kind = $urandom_range(0, 9);
      case (sel)
        0: addr = BASE + 32'h00;
        1: addr = BASE + 32'h04;
        2: addr = BASE + 32'h08;
        3: addr = BASE + 32'h0C;
        4: addr = BASE + 32'h10;
        5: addr = BASE + 32'h14;
        6: addr = BASE + 32'h18;
        7: addr = BASE + 32'h40 + 32'($urandom_range(0, 3));
        8: addr = 32'h7FFF_FF04;
        default: addr = BASE + 32'h04 + 32'($urandom_range(0, 3));
      endcase
      re = (kind <= 3) || (kind == 7);
      we = (kind == 4) || (kind == 5) || (kind == 7);
      wdata = $urandom;
      if (sel == 6 && $urandom_range(0, 3) != 0) we = 0;
      instr_retired = $urandom_range(0, 1);
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      if (!(uart_rx_valid && !uart_rx_ready)) begin
        uart_rx_valid = ($urandom_range(0, 1) == 1);
        uart_rx_data  = 8'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle();
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
